// File: rtl/load_use_hazard_unit_pkg.sv
// Shared constants and types for the ID-stage load-use hazard logic.
// The NOP word is what IF/ID and ID/EX users load when this unit flushes or bubbles.
package load_use_hazard_unit_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int ZERO_REG       = 0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_FLUSH,
        MODE_STALL,
        MODE_FREEZE
    } hazMode_t;

endpackage

// File: rtl/load_use_hazard_unit_scoreboard.sv
// Shift register of in-flight loads {valid, rd} past EX. It holds while the pipeline is frozen.
// Only the valid bits are reset; rd is qualified by valid and needs no reset.
module hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    hold,
    input  logic                    inV,
    input  logic [ADDR_W-1:0]       inRd,
    output logic [DEPTH-1:0]        sbV,
    output logic [DEPTH*ADDR_W-1:0] sbRd
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sbV <= '0;
        end else if (!hold) begin
            for (int j = DEPTH - 1; j > 0; j--) begin
                sbV[j] <= sbV[j-1];
            end
            sbV[0] <= inV;
        end
    end

    always_ff @(posedge clk) begin
        if (!hold) begin
            for (int j = DEPTH - 1; j > 0; j--) begin
                sbRd[j*ADDR_W +: ADDR_W] <= sbRd[(j-1)*ADDR_W +: ADDR_W];
            end
            sbRd[0 +: ADDR_W] <= inRd;
        end
    end

endmodule

// File: rtl/load_use_hazard_unit.sv
// ID-stage load-use hazard detector with freeze/stall/flush arbitration.
// It also keeps a saturating count of stall cycles.
module load_use_hazard_unit
    import load_use_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr_i,
    input  logic [NUM_SRC-1:0]            id_src_valid_i,
    input  logic                          ex_memread_i,
    input  logic [REG_ADDR_W-1:0]         ex_rd_addr_i,
    input  logic                          mem_stall_i,
    input  logic                          branch_taken_i,
    input  logic                          perf_clr_i,
    output logic                          pc_write_o,
    output logic                          if_id_write_o,
    output logic                          if_id_flush_o,
    output logic                          id_ex_bubble_o,
    output logic                          stall_o,
    output logic [CNT_W-1:0]              stall_cnt_o
);

    localparam int SB_N = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [SB_N-1:0]            sbV;
    logic [SB_N*REG_ADDR_W-1:0] sbRd;
    logic [NUM_SRC-1:0]         srcHit;
    logic                       hazard;
    hazMode_t                   mode;

    generate
        if (LOAD_LAT > 1) begin : g_sb
            hazard_scoreboard #(
                .ADDR_W(REG_ADDR_W),
                .DEPTH (LOAD_LAT - 1)
            ) u_sb (
                .clk (clk_i),
                .rstN(rst_i),
                .hold(mem_stall_i),
                .inV (ex_memread_i && (ex_rd_addr_i != ZERO_ADDR)),
                .inRd(ex_rd_addr_i),
                .sbV (sbV),
                .sbRd(sbRd)
            );
        end else begin : g_noSb
            assign sbV  = '0;
            assign sbRd = '0;
        end
    endgenerate

    // One comparator set per source: the EX load plus every pending scoreboard load.
    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            logic [REG_ADDR_W-1:0] srcAddr;
            logic                  hit;

            always_comb begin
                srcAddr = id_src_addr_i[k*REG_ADDR_W +: REG_ADDR_W];
                hit     = ex_memread_i && (ex_rd_addr_i == srcAddr);
                for (int j = 0; j < SB_N; j++) begin
                    hit = hit || (sbV[j] && (sbRd[j*REG_ADDR_W +: REG_ADDR_W] == srcAddr));
                end
                hit = hit && id_src_valid_i[k] && (srcAddr != ZERO_ADDR);
            end

            assign srcHit[k] = hit;
        end
    endgenerate

    assign hazard = |srcHit;

    always_comb begin
        if (mem_stall_i)         mode = MODE_FREEZE;
        else if (hazard)         mode = MODE_STALL;
        else if (branch_taken_i) mode = MODE_FLUSH;
        else                     mode = MODE_IDLE;
    end

    // Outputs are forced inactive while reset is asserted, independent of the clock.
    always_comb begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        stall_o        = 1'b0;
        if (rst_i) begin
            unique case (mode)
                MODE_FREEZE: ;
                MODE_STALL: begin
                    id_ex_bubble_o = 1'b1;
                    stall_o        = 1'b1;
                end
                MODE_FLUSH: begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                    if_id_flush_o = 1'b1;
                end
                default: begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (perf_clr_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o) begin
            stall_cnt_o <= satInc(stall_cnt_o);
        end
    end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Bench for load_use_hazard_unit: two instances (LOAD_LAT=1/CNT_W=4 and LOAD_LAT=3/CNT_W=16)
// checked every cycle against a history-based model, plus directed pipeline scenarios.
module tb_load_use_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN[2];
    logic [9:0] srcAddr[2];
    logic [1:0] srcValid[2];
    logic       exMemread[2];
    logic [4:0] exRd[2];
    logic       memStall[2];
    logic       branch[2];
    logic       perfClr[2];
    logic       pcWrite[2];
    logic       ifIdWrite[2];
    logic       ifIdFlush[2];
    logic       idExBubble[2];
    logic       stallO[2];
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    int lat[2]    = '{1, 3};
    int cntMax[2] = '{15, 65535};

    int nTests = 0;
    int nFail  = 0;

    load_use_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(4)) dut0 (
        .clk_i(clk), .rst_i(rstN[0]), .id_src_addr_i(srcAddr[0]), .id_src_valid_i(srcValid[0]),
        .ex_memread_i(exMemread[0]), .ex_rd_addr_i(exRd[0]), .mem_stall_i(memStall[0]),
        .branch_taken_i(branch[0]), .perf_clr_i(perfClr[0]), .pc_write_o(pcWrite[0]),
        .if_id_write_o(ifIdWrite[0]), .if_id_flush_o(ifIdFlush[0]), .id_ex_bubble_o(idExBubble[0]),
        .stall_o(stallO[0]), .stall_cnt_o(cnt0)
    );

    load_use_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rstN[1]), .id_src_addr_i(srcAddr[1]), .id_src_valid_i(srcValid[1]),
        .ex_memread_i(exMemread[1]), .ex_rd_addr_i(exRd[1]), .mem_stall_i(memStall[1]),
        .branch_taken_i(branch[1]), .perf_clr_i(perfClr[1]), .pc_write_o(pcWrite[1]),
        .if_id_write_o(ifIdWrite[1]), .if_id_flush_o(ifIdFlush[1]), .id_ex_bubble_o(idExBubble[1]),
        .stall_o(stallO[1]), .stall_cnt_o(cnt1)
    );

    // Model: what EX held on each recent unfrozen cycle (index 0 = most recent).
    bit         hV[2][4];
    logic [4:0] hRd[2][4];
    int         mCnt[2];

    task automatic check(input string name, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit mHazard(input int s);
        logic [4:0] a;
        for (int k = 0; k < 2; k++) begin
            a = srcAddr[s][k*5 +: 5];
            if (srcValid[s][k] && a != 5'd0) begin
                if (exMemread[s] && exRd[s] == a) return 1'b1;
                for (int j = 0; j < lat[s] - 1; j++)
                    if (hV[s][j] && hRd[s][j] == a) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int dutCnt(input int s);
        return (s == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    task automatic clearModel(input int s);
        for (int j = 0; j < 4; j++) begin
            hV[s][j]  = 1'b0;
            hRd[s][j] = 5'd0;
        end
        mCnt[s] = 0;
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            bit ePc, eIfId, eFlush, eBub, eStall;
            if (!rstN[s]) clearModel(s);
            {ePc, eIfId, eFlush, eBub, eStall} = 5'b00000;
            if (rstN[s] && !memStall[s]) begin
                if (mHazard(s))   {eBub, eStall} = 2'b11;
                else if (branch[s]) {ePc, eIfId, eFlush} = 3'b111;
                else              {ePc, eIfId} = 2'b11;
            end
            check($sformatf("pc_write[%0d]", s), int'(pcWrite[s]), int'(ePc));
            check($sformatf("if_id_write[%0d]", s), int'(ifIdWrite[s]), int'(eIfId));
            check($sformatf("if_id_flush[%0d]", s), int'(ifIdFlush[s]), int'(eFlush));
            check($sformatf("id_ex_bubble[%0d]", s), int'(idExBubble[s]), int'(eBub));
            check($sformatf("stall[%0d]", s), int'(stallO[s]), int'(eStall));
            check($sformatf("stall_cnt[%0d]", s), dutCnt(s), mCnt[s]);
        end
    end

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rstN[s]) begin
                clearModel(s);
            end else begin
                bit st;
                st = !memStall[s] && mHazard(s);
                if (!memStall[s]) begin
                    for (int j = 3; j > 0; j--) begin
                        hV[s][j]  = hV[s][j-1];
                        hRd[s][j] = hRd[s][j-1];
                    end
                    hV[s][0]  = exMemread[s];
                    hRd[s][0] = exRd[s];
                end
                if (perfClr[s]) mCnt[s] = 0;
                else if (st && mCnt[s] < cntMax[s]) mCnt[s] = mCnt[s] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int s);
        srcAddr[s] = '0; srcValid[s] = '0; exMemread[s] = 1'b0; exRd[s] = '0;
        memStall[s] = 1'b0; branch[s] = 1'b0; perfClr[s] = 1'b0;
    endtask

    task automatic consumer(input int s, input logic [4:0] rd);
        srcAddr[s]  = {5'd9, rd};
        srcValid[s] = 2'b11;
    endtask

    // Emulates the pipeline around one load: consumer at distance d; counts stall cycles.
    task automatic stallRun(input int s, input int d, input logic [4:0] rd, output int n);
        idle(s);
        repeat (4) tick();
        exMemread[s] = 1'b1; exRd[s] = rd;
        if (d == 1) consumer(s, rd);
        for (int st = 1; st < d; st++) begin
            tick();
            exMemread[s] = 1'b0; exRd[s] = 5'd7;
            if (st == d - 1) consumer(s, rd);
            else srcValid[s] = 2'b00;
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!stallO[s]) break;
            n++;
            tick();
            exMemread[s] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int s = 0; s < 2; s++) begin
            rstN[s] = 1'b0;
            idle(s);
        end
        #3;
        check("reset pc_write", int'(pcWrite[0]), 0);
        check("reset if_id_write", int'(ifIdWrite[1]), 0);
        check("reset cnt", int'(cnt0), 0);
        tick(); tick();
        rstN[0] = 1'b1; rstN[1] = 1'b1;

        // LOAD_LAT=1: adjacent consumer stalls once, with bubble, counter becomes 1.
        stallRun(0, 1, 5'd3, n);
        check("lat1 d1 stalls", n, 1);
        check("lat1 cnt after stall", int'(cnt0), 1);
        stallRun(0, 2, 5'd3, n);
        check("lat1 d2 stalls", n, 0);

        // Unused sources and $0 never stall.
        tick(); idle(0);
        exMemread[0] = 1'b1; exRd[0] = 5'd3; srcAddr[0] = {5'd3, 5'd3}; srcValid[0] = 2'b00;
        @(negedge clk);
        check("invalid src stall", int'(stallO[0]), 0);
        check("invalid src pc_write", int'(pcWrite[0]), 1);
        tick();
        exRd[0] = 5'd0; srcAddr[0] = 10'd0; srcValid[0] = 2'b01;
        @(negedge clk);
        check("reg0 stall", int'(stallO[0]), 0);

        // Branch is ignored under a hazard and flushes otherwise.
        tick(); idle(0);
        exMemread[0] = 1'b1; exRd[0] = 5'd3; consumer(0, 5'd3); branch[0] = 1'b1;
        @(negedge clk);
        check("branch+hazard flush", int'(ifIdFlush[0]), 0);
        check("branch+hazard bubble", int'(idExBubble[0]), 1);
        tick(); idle(0); branch[0] = 1'b1;
        @(negedge clk);
        check("branch flush", int'(ifIdFlush[0]), 1);
        check("branch pc_write", int'(pcWrite[0]), 1);

        // Saturation at 4 bits, then clear wins over a simultaneous stall.
        tick(); idle(0);
        exMemread[0] = 1'b1; exRd[0] = 5'd4; consumer(0, 5'd4);
        repeat (20) tick();
        @(negedge clk);
        check("cnt saturated", int'(cnt0), 15);
        tick(); perfClr[0] = 1'b1;
        tick(); perfClr[0] = 1'b0; idle(0);
        @(negedge clk);
        check("cnt cleared", int'(cnt0), 0);

        // LOAD_LAT=3: freeze during a stall holds everything; remaining stall resumes.
        idle(1); repeat (4) tick();
        exMemread[1] = 1'b1; exRd[1] = 5'd5; consumer(1, 5'd5);
        @(negedge clk);
        check("freeze pre stall0", int'(stallO[1]), 1);
        tick(); exMemread[1] = 1'b0;
        @(negedge clk);
        check("freeze pre stall1", int'(stallO[1]), 1);
        tick(); memStall[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("freeze pc_write", int'(pcWrite[1]), 0);
            check("freeze bubble", int'(idExBubble[1]), 0);
            check("freeze stall", int'(stallO[1]), 0);
            check("freeze cnt", int'(cnt1), 2);
            tick();
        end
        memStall[1] = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!stallO[1]) break;
            n++;
            tick();
        end
        check("freeze remaining stalls", n, 1);
        check("freeze cnt after", int'(cnt1), 3);

        stallRun(1, 1, 5'd5, n); check("lat3 d1 stalls", n, 3);
        stallRun(1, 2, 5'd5, n); check("lat3 d2 stalls", n, 2);
        stallRun(1, 3, 5'd5, n); check("lat3 d3 stalls", n, 1);
        stallRun(1, 4, 5'd5, n); check("lat3 d4 stalls", n, 0);

        // Async reset mid-stall: outputs drop at once and pending loads are forgotten.
        tick(); idle(1);
        exMemread[1] = 1'b1; exRd[1] = 5'd6; consumer(1, 5'd6);
        tick(); exMemread[1] = 1'b0;
        @(negedge clk);
        check("pre-reset stall", int'(stallO[1]), 1);
        #2 rstN[1] = 1'b0;
        #1;
        check("async reset stall", int'(stallO[1]), 0);
        check("async reset pc_write", int'(pcWrite[1]), 0);
        check("async reset bubble", int'(idExBubble[1]), 0);
        check("async reset cnt", int'(cnt1), 0);
        tick(); rstN[1] = 1'b1;
        @(negedge clk);
        check("post-reset stall", int'(stallO[1]), 0);
        check("post-reset pc_write", int'(pcWrite[1]), 1);

        // Random traffic on both instances, checked by the per-cycle model.
        tick();
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 2; s++) begin
                srcAddr[s]   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
                srcValid[s]  = 2'($urandom_range(0, 3));
                exMemread[s] = 1'($urandom_range(0, 1));
                exRd[s]      = 5'($urandom_range(0, 3));
                memStall[s]  = ($urandom_range(0, 7) == 0);
                branch[s]    = 1'($urandom_range(0, 1));
                perfClr[s]   = ($urandom_range(0, 15) == 0);
                rstN[s]      = ($urandom_range(0, 99) != 0);
            end
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            idle(s);
            rstN[s] = 1'b1;
        end
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
